// File: rtl/pico_bus_router.sv
// Router between the Pico parallel bus and NUM_SRC pixel sources: control register file,
// registered LCD source select and a capture FIFO drained over the same bus.
module pico_bus_router #(
    parameter int DATA_W      = 8,
    parameter int NUM_SRC     = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bus_cs_n,
    input  logic                      bus_wr_n,
    input  logic                      bus_rd_n,
    input  logic                      bus_cd,
    input  logic [DATA_W-1:0]         bus_din,
    output logic [DATA_W-1:0]         bus_dout,
    output logic                      bus_oe,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [DATA_W-1:0]         lcd_data,
    output logic                      lcd_valid,
    output logic                      cap_ovf
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [DATA_W-1:0] A_CTRL  = DATA_W'(0);
    localparam logic [DATA_W-1:0] A_LSEL  = DATA_W'(1);
    localparam logic [DATA_W-1:0] A_CSEL  = DATA_W'(2);
    localparam logic [DATA_W-1:0] A_STAT  = DATA_W'(3);
    localparam logic [DATA_W-1:0] A_FDATA = DATA_W'(4);
    localparam logic [DATA_W-1:0] A_LEVEL = DATA_W'(5);

    // Strobe synchronisers idle high so reset never manufactures an edge.
    logic [SYNC_STAGES-1:0]             cs_sync, wr_sync, rd_sync, cd_sync;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] din_sync;
    logic                               wr_q, rd_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_sync  <= '1;
            wr_sync  <= '1;
            rd_sync  <= '1;
            cd_sync  <= '1;
            din_sync <= '0;
            wr_q     <= 1'b1;
            rd_q     <= 1'b1;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus_cs_n};
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], bus_wr_n};
            rd_sync  <= {rd_sync[SYNC_STAGES-2:0], bus_rd_n};
            cd_sync  <= {cd_sync[SYNC_STAGES-2:0], bus_cd};
            din_sync <= {din_sync[SYNC_STAGES-2:0], bus_din};
            wr_q     <= wr_sync[SYNC_STAGES-1];
            rd_q     <= rd_sync[SYNC_STAGES-1];
        end
    end

    logic              cs_s, wr_s, rd_s, cd_s;
    logic [DATA_W-1:0] din_s;
    assign cs_s  = cs_sync[SYNC_STAGES-1];
    assign wr_s  = wr_sync[SYNC_STAGES-1];
    assign rd_s  = rd_sync[SYNC_STAGES-1];
    assign cd_s  = cd_sync[SYNC_STAGES-1];
    assign din_s = din_sync[SYNC_STAGES-1];

    logic              wr_commit, data_wr, rd_start, rd_end, rd_fdata;
    logic [DATA_W-1:0] addr_q, lsel, csel, rdata;
    logic              cap_en, flush, stat_clr;

    assign wr_commit = wr_s & ~wr_q & ~cs_s;
    assign data_wr   = wr_commit & ~cd_s;
    assign rd_start  = ~rd_s & rd_q & ~cs_s;
    assign rd_end    = rd_s & ~rd_q & bus_oe;
    assign flush     = data_wr && (addr_q == A_CTRL) && din_s[1];
    assign stat_clr  = data_wr && (addr_q == A_STAT) && din_s[2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q <= '0;
            cap_en <= 1'b0;
            lsel   <= '0;
            csel   <= '0;
        end else if (wr_commit) begin
            if (cd_s) begin
                addr_q <= din_s;
            end else begin
                case (addr_q)
                    A_CTRL:  cap_en <= din_s[0];
                    A_LSEL:  lsel   <= din_s;
                    A_CSEL:  csel   <= din_s;
                    default: ;
                endcase
            end
        end
    end

    // Channel 0 is the Pico itself: each committed data write is one sample.
    logic [NUM_SRC-1:0][DATA_W-1:0] ch_data;
    logic [NUM_SRC-1:0]             ch_valid;
    always_comb begin
        ch_data     = src_data;
        ch_valid    = src_valid;
        ch_data[0]  = din_s;
        ch_valid[0] = data_wr;
    end

    logic lsel_ok, csel_ok;
    assign lsel_ok = lsel < DATA_W'(NUM_SRC);
    assign csel_ok = csel < DATA_W'(NUM_SRC);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lcd_data  <= '0;
            lcd_valid <= 1'b0;
        end else if (lsel_ok) begin
            lcd_data  <= ch_data[lsel[SEL_W-1:0]];
            lcd_valid <= ch_valid[lsel[SEL_W-1:0]];
        end else begin
            lcd_data  <= '0;
            lcd_valid <= 1'b0;
        end
    end

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [LVL_W-1:0]  level;
    logic              empty, full, push_req, pop_req, push_ok, pop_ok, drop;

    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign push_req = cap_en && csel_ok && ch_valid[csel[SEL_W-1:0]];
    assign pop_req  = rd_end && rd_fdata;
    assign pop_ok   = pop_req && !empty && !flush;
    // A full FIFO still accepts a push when a pop frees the slot that same cycle.
    assign push_ok  = push_req && !flush && (!full || pop_ok);
    assign drop     = push_req && !flush && full && !pop_ok;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= ch_data[csel[SEL_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            cap_ovf <= 1'b0;
        end else begin
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (push_ok) wptr <= wptr + 1'b1;
                if (pop_ok)  rptr <= rptr + 1'b1;
                if (push_ok && !pop_ok)      level <= level + 1'b1;
                else if (pop_ok && !push_ok) level <= level - 1'b1;
            end
            if (stat_clr)  cap_ovf <= 1'b0;
            else if (drop) cap_ovf <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr_q)
            A_CTRL:  rdata[0]   = cap_en;
            A_LSEL:  rdata      = lsel;
            A_CSEL:  rdata      = csel;
            A_STAT:  rdata[2:0] = {cap_ovf, full, empty};
            A_FDATA: if (!empty) rdata = mem[rptr];
            A_LEVEL: rdata      = DATA_W'(level);
            default: ;
        endcase
    end

    // Read data is latched at strobe start and held; the FIFO pops only when it ends.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_dout <= '0;
            bus_oe   <= 1'b0;
            rd_fdata <= 1'b0;
        end else if (rd_start) begin
            bus_dout <= rdata;
            bus_oe   <= 1'b1;
            rd_fdata <= (addr_q == A_FDATA);
        end else if (rd_end) begin
            bus_oe   <= 1'b0;
            rd_fdata <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pico_bus_router.sv
// Directed bench for pico_bus_router; capture FIFO contents are tracked in a scoreboard queue.
module tb_pico_bus_router;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int FD = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          bus_cs_n = 1'b1, bus_wr_n = 1'b1, bus_rd_n = 1'b1, bus_cd = 1'b1;
    logic [DW-1:0] bus_din = '0;
    logic [DW-1:0] bus_dout;
    logic          bus_oe;
    logic [NS*DW-1:0] src_data = '0;
    logic [NS-1:0]    src_valid = '0;
    logic [DW-1:0] lcd_data;
    logic          lcd_valid;
    logic          cap_ovf;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_val;
    logic [7:0] pulse_val;

    pico_bus_router #(.DATA_W(DW), .NUM_SRC(NS), .FIFO_DEPTH(FD), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bus_cs_n(bus_cs_n), .bus_wr_n(bus_wr_n), .bus_rd_n(bus_rd_n),
        .bus_cd(bus_cd), .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe),
        .src_data(src_data), .src_valid(src_valid), .lcd_data(lcd_data),
        .lcd_valid(lcd_valid), .cap_ovf(cap_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Optionally drives one channel-1 sample in the cycle the strobe's rising edge takes effect.
    task automatic edge_pulse(input bit pulse);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if (pulse) begin
            src_data[1*DW +: DW] = pulse_val;
            src_valid[1] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        src_valid[1] = 1'b0;
    endtask

    task automatic bus_write(input logic cd, input logic [7:0] d, input bit pulse);
        @(negedge clk);
        bus_cs_n = 1'b0; bus_cd = cd; bus_din = d; bus_wr_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus_wr_n = 1'b1;
        edge_pulse(pulse);
        bus_cs_n = 1'b1;
    endtask

    task automatic bus_read(output logic [7:0] d, input bit pulse);
        int n;
        @(negedge clk);
        bus_cs_n = 1'b0; bus_rd_n = 1'b0;
        n = 0;
        while (!bus_oe && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("read_oe_on", bus_oe, 1);
        d = bus_dout;
        bus_rd_n = 1'b1;
        edge_pulse(pulse);
        check("read_oe_off", bus_oe, 0);
        bus_cs_n = 1'b1;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d, input bit pulse);
        bus_write(1'b1, a, 1'b0);
        bus_write(1'b0, d, pulse);
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
        bus_write(1'b1, a, 1'b0);
        bus_read(d, 1'b0);
    endtask

    task automatic push_src1(input logic [7:0] v);
        @(negedge clk);
        src_data[1*DW +: DW] = v;
        src_valid[1] = 1'b1;
        if (exp_q.size() < FD) exp_q.push_back(v);
        @(negedge clk);
        src_valid[1] = 1'b0;
    endtask

    initial begin
        // 1: reset with random strobe activity
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_cs_n = 1'($urandom); bus_wr_n = 1'($urandom); bus_rd_n = 1'($urandom);
            bus_cd = 1'($urandom); bus_din = 8'($urandom);
            src_data = 32'($urandom); src_valid = 4'($urandom);
        end
        check("rst_bus_dout", bus_dout, 0);
        check("rst_bus_oe", bus_oe, 0);
        check("rst_lcd_data", lcd_data, 0);
        check("rst_lcd_valid", lcd_valid, 0);
        check("rst_cap_ovf", cap_ovf, 0);
        bus_cs_n = 1'b1; bus_wr_n = 1'b1; bus_rd_n = 1'b1; bus_cd = 1'b1; bus_din = '0;
        src_data = '0; src_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        read_reg(8'h03, rd_val);
        check("rst_stat", rd_val, 8'h01);

        // 2: LCD select
        write_reg(8'h01, 8'h02, 1'b0);
        @(negedge clk);
        src_data[2*DW +: DW] = 8'hA5; src_valid[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lcd_sel2_data", lcd_data, 8'hA5);
        check("lcd_sel2_valid", lcd_valid, 1);
        write_reg(8'h01, 8'h07, 1'b0);
        @(negedge clk);
        check("lcd_oob_data", lcd_data, 0);
        check("lcd_oob_valid", lcd_valid, 0);
        src_valid[2] = 1'b0;

        // 3: overfill capture FIFO from channel 1
        write_reg(8'h02, 8'h01, 1'b0);
        write_reg(8'h00, 8'h01, 1'b0);
        for (int i = 0; i < 20; i++) push_src1(8'(i));
        read_reg(8'h05, rd_val);
        check("fill_level", rd_val, FD);
        read_reg(8'h03, rd_val);
        check("fill_stat", rd_val, 8'h06);
        check("fill_cap_ovf", cap_ovf, 1);
        bus_write(1'b1, 8'h04, 1'b0);
        for (int i = 0; i < FD; i++) begin
            bus_read(rd_val, 1'b0);
            check("drain_fdata", rd_val, exp_q.pop_front());
        end
        read_reg(8'h03, rd_val);
        check("drain_stat", rd_val, 8'h05);

        // 4: clear overflow, empty FDATA read
        write_reg(8'h03, 8'h04, 1'b0);
        check("ovf_clear", cap_ovf, 0);
        read_reg(8'h04, rd_val);
        check("empty_fdata", rd_val, 0);
        read_reg(8'h05, rd_val);
        check("empty_level", rd_val, 0);

        // 5: pop+push when full, then flush with concurrent push
        for (int i = 0; i < FD; i++) push_src1(8'h40 + 8'(i));
        read_reg(8'h05, rd_val);
        check("refill_level", rd_val, FD);
        bus_write(1'b1, 8'h04, 1'b0);
        pulse_val = 8'h99;
        bus_read(rd_val, 1'b1);
        check("full_popush_data", rd_val, exp_q.pop_front());
        exp_q.push_back(8'h99);
        read_reg(8'h05, rd_val);
        check("full_popush_level", rd_val, FD);
        check("full_popush_ovf", cap_ovf, 0);
        bus_write(1'b1, 8'h04, 1'b0);
        bus_read(rd_val, 1'b0);
        check("after_popush_head", rd_val, exp_q.pop_front());
        pulse_val = 8'h77;
        write_reg(8'h00, 8'h03, 1'b1);
        exp_q.delete();
        read_reg(8'h05, rd_val);
        check("flush_level", rd_val, 0);

        // 6: reset in the middle of an FDATA read
        push_src1(8'h5A);
        bus_write(1'b1, 8'h04, 1'b0);
        @(negedge clk);
        bus_cs_n = 1'b0; bus_rd_n = 1'b0;
        for (int n = 0; n < 12 && !bus_oe; n++) @(negedge clk);
        check("midrd_oe_on", bus_oe, 1);
        rst = 1'b0; bus_rd_n = 1'b1; bus_cs_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrd_oe_off", bus_oe, 0);
        @(negedge clk);
        rst = 1'b1;
        bus_write(1'b0, 8'h01, 1'b0);
        bus_read(rd_val, 1'b0);
        check("post_rst_addr0", rd_val, 8'h01);
        read_reg(8'h05, rd_val);
        check("post_rst_level", rd_val, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
